pipe_issue_ctrl: RTL and testbench

Issue scheduler placed in front of the 4-stage 8-bit pipeline (IF/ID/EX/MEM/WB register chain; 8-entry regfile; no forwarding). It accepts instructions, with optional load operands, from a requester over a valid/ready handshake and buffers them in a small FIFO. It issues them in order, inserting bubbles on read-after-write hazards, and times load data onto the pipeline's data_in. It also flags the cycle in which the pipeline's result output becomes valid.

---
 rtl/pp_pkg.sv | 41 ++++
 rtl/pp_req_fifo.sv | 58 +++++
 rtl/pipe_issue_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared definitions for the pipeline issue scheduler.
// Contents: opcode constants, instruction field positions, the default
// bubble encoding, scoreboard entry type and per-opcode register-usage
// helpers.
package pp_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LD  = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 6;
    localparam int SRC2_HI = 5;
    localparam int SRC2_LO = 3;
    localparam int DST_HI  = 2;
    localparam int DST_LO  = 0;

    // CLR r0: r0 is the reserved discard register, so this is a no-op.
    localparam logic [7:0] BUBBLE_INSTR_DEF = 8'hC0;

    // One issue slot's register write, as seen by the hazard check.
    typedef struct packed {
        logic       wr;
        logic [2:0] dst;
    } sb_entry_t;

    function automatic logic reads_src1(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic reads_src2(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // LD writes the pipeline's result register, never the regfile.
    function automatic logic writes_reg(input logic [1:0] op);
        return op != OP_LD;
    endfunction

endpackage

// File: rtl/pp_req_fifo.sv
// Request FIFO for the issue scheduler.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   i_push/i_din write one entry (ignored when full)
//   i_pop        remove the head entry (ignored when empty)
//   o_dout       head entry (valid when !o_empty)
//   o_full       no free entries
//   o_empty      no entries
module pp_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue scheduler for the 4-stage 8-bit pipeline (no forwarding).
// Buffers requests, issues them one per slot with bubbles on RAW hazards,
// times load operands onto the pipeline's data_in and flags result validity.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (req_ready = FIFO not full)
//   req_instr, req_data        instruction and load operand
//   halt                       issue bubbles only; FIFO still accepts
//   pp_instr, pp_data          registered drive to pipeline instr_in/data_in
//   issue_valid                pp_instr is a real instruction
//   result_valid               pipeline result holds a load value (1 cycle)
//   busy                       queued or in-flight work exists
//   issue_cnt, stall_cnt       saturating issue / hazard-stall counters
module pipe_issue_ctrl
    import pp_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_instr,
    input  logic [7:0]       req_data,
    input  logic             halt,
    output logic [7:0]       pp_instr,
    output logic [7:0]       pp_data,
    output logic             issue_valid,
    output logic             result_valid,
    output logic             busy,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [15:0]       w_fifo_dout;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_stall;
    logic              w_hazard;
    logic [7:0]        w_head_instr;
    logic [7:0]        w_head_data;
    logic [1:0]        w_head_op;
    logic [2:0]        w_head_src2;
    logic [2:0]        w_head_dst;
    logic              w_head_is_ld;
    sb_entry_t         w_sb_new;

    // r_sb[0] is the most recent issue slot, r_sb[2] the oldest tracked.
    sb_entry_t [2:0]   r_sb;
    logic              r_ld_vld_p0;
    logic              r_ld_vld_p1;
    logic [7:0]        r_ld_data_p0;
    logic [7:0]        r_ld_data_p1;
    logic [4:0]        r_res_vld_p;
    logic [7:0]        r_pp_instr;
    logic [7:0]        r_pp_data;
    logic              r_issue_valid;
    logic              r_result_valid;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;

    pp_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_din   ({req_data, req_instr}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_head_instr = w_fifo_dout[7:0];
    assign w_head_data  = w_fifo_dout[15:8];
    assign w_head_op    = w_head_instr[OP_HI:OP_LO];
    assign w_head_src2  = w_head_instr[SRC2_HI:SRC2_LO];
    assign w_head_dst   = w_head_instr[DST_HI:DST_LO];
    assign w_head_is_ld = (w_head_op == OP_LD);

    // A producer stays visible for three slots, so a consumer issues at
    // least four slots later and reads the regfile after WB. r0 never blocks.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (r_sb[i].wr && (r_sb[i].dst != 3'd0)) begin
                if (reads_src1(w_head_op) && (r_sb[i].dst == w_head_dst))
                    w_hazard = 1'b1;
                if (reads_src2(w_head_op) && (r_sb[i].dst == w_head_src2))
                    w_hazard = 1'b1;
            end
        end
    end

    assign w_pop   = !w_empty && !halt && !w_hazard;
    assign w_stall = !w_empty && !halt && w_hazard;

    always_comb begin
        w_sb_new.wr  = w_pop && writes_reg(w_head_op);
        w_sb_new.dst = w_head_dst;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pp_instr     <= BUBBLE_INSTR;
            r_pp_data      <= 8'h00;
            r_issue_valid  <= 1'b0;
            r_result_valid <= 1'b0;
            r_sb           <= '0;
            r_ld_vld_p0    <= 1'b0;
            r_ld_vld_p1    <= 1'b0;
            r_res_vld_p    <= '0;
            r_issue_cnt    <= '0;
            r_stall_cnt    <= '0;
        end else begin
            // p0: issue slot
            r_pp_instr    <= w_pop ? w_head_instr : BUBBLE_INSTR;
            r_issue_valid <= w_pop;
            r_sb          <= {r_sb[1:0], w_sb_new};
            r_ld_vld_p0   <= w_pop && w_head_is_ld;
            r_res_vld_p   <= {r_res_vld_p[3:0], w_pop && w_head_is_ld};
            // p1 -> data_in: operand lands while the LD is in EX
            r_ld_vld_p1   <= r_ld_vld_p0;
            if (r_ld_vld_p1) r_pp_data <= r_ld_data_p1;
            // p4 -> result_valid: same edge the pipeline writes result
            r_result_valid <= r_res_vld_p[4];
            if (w_pop)   r_issue_cnt <= sat_inc(r_issue_cnt);
            if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
        end
    end

    always_ff @(posedge clk) begin
        r_ld_data_p0 <= w_head_data;
        r_ld_data_p1 <= r_ld_data_p0;
    end

    assign pp_instr     = r_pp_instr;
    assign pp_data      = r_pp_data;
    assign issue_valid  = r_issue_valid;
    assign result_valid = r_result_valid;
    assign issue_cnt    = r_issue_cnt;
    assign stall_cnt    = r_stall_cnt;
    assign busy         = !w_empty || r_sb[0].wr || r_sb[1].wr || r_sb[2].wr ||
                          r_ld_vld_p0 || r_ld_vld_p1 || (|r_res_vld_p);

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
module tb_pipe_issue_ctrl;

    localparam int         DEPTH = 4;
    localparam int         CW    = 6;
    localparam logic [7:0] BUB   = 8'hC0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [7:0]    req_instr = 8'h00;
    logic [7:0]    req_data = 8'h00;
    logic          halt = 1'b0;
    logic          req_ready;
    logic [7:0]    pp_instr;
    logic [7:0]    pp_data;
    logic          issue_valid;
    logic          result_valid;
    logic          busy;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] stall_cnt;

    pipe_issue_ctrl #(
        .FIFO_DEPTH   (DEPTH),
        .BUBBLE_INSTR (BUB),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_instr    (req_instr),
        .req_data     (req_data),
        .halt         (halt),
        .pp_instr     (pp_instr),
        .pp_data      (pp_data),
        .issue_valid  (issue_valid),
        .result_valid (result_valid),
        .busy         (busy),
        .issue_cnt    (issue_cnt),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int         edge_n;
        logic [7:0] val;
    } exp_t;

    exp_t        q_issue[$];
    exp_t        q_data[$];
    int          q_rv[$];
    logic [15:0] m_fifo[$];
    int          m_last_wr[8];
    int          m_last_any_wr;
    int          m_last_ld;
    int          m_issue;
    int          m_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    // A consumer must sit at least 4 issue slots after the last writer of
    // any non-zero register it reads. Only ADD/SUB (op[1]==0) read.
    function automatic bit m_blocked(input logic [7:0] ins, input int e);
        int srcs[2];
        if (ins[7]) return 1'b0;
        srcs[0] = int'(ins[2:0]);
        srcs[1] = int'(ins[5:3]);
        foreach (srcs[k])
            if (srcs[k] != 0 && (e - m_last_wr[srcs[k]]) < 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clear();
        m_fifo.delete();
        q_issue.delete();
        q_data.delete();
        q_rv.delete();
        foreach (m_last_wr[r]) m_last_wr[r] = -100;
        m_last_any_wr = -100;
        m_last_ld     = -100;
        m_issue       = 0;
        m_stall       = 0;
    endtask

    // One clock: check the state left by the previous edge, drive inputs
    // for the next edge and advance the reference model.
    task automatic step(input bit rst, input bit v, input logic [7:0] ins,
                        input logic [7:0] d, input bit h, output bit acc);
        int         e;
        bit         bexp;
        logic [15:0] head;
        @(negedge clk);
        #1;
        if (mon_en) begin
            chk("req_ready", req_ready, m_fifo.size() < DEPTH);
            bexp = (m_fifo.size() > 0) || (cyc - m_last_any_wr <= 2) || (cyc - m_last_ld <= 4);
            chk("busy", busy, bexp);
            chk("issue_cnt", issue_cnt, m_issue);
            chk("stall_cnt", stall_cnt, m_stall);
        end
        reset = rst; req_valid = v; req_instr = ins; req_data = d; halt = h;
        e   = cyc + 1;
        acc = v && (m_fifo.size() < DEPTH);
        if (rst) begin
            acc = 1'b0;
            m_clear();
            return;
        end
        if (m_fifo.size() > 0 && !h) begin
            head = m_fifo[0];
            if (m_blocked(head[7:0], e)) begin
                m_stall = sat(m_stall);
            end else begin
                void'(m_fifo.pop_front());
                m_issue = sat(m_issue);
                q_issue.push_back('{e, head[7:0]});
                if (head[7:6] == 2'b10) begin
                    q_data.push_back('{e + 2, head[15:8]});
                    q_rv.push_back(e + 5);
                    m_last_ld = e;
                end else begin
                    m_last_wr[head[2:0]] = e;
                    m_last_any_wr = e;
                end
            end
        end
        if (acc) m_fifo.push_back({d, ins});
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, a);
    endtask

    task automatic send(input logic [7:0] ins, input logic [7:0] d, input bit h);
        bit a;
        a = 1'b0;
        for (int i = 0; i < 20 && !a; i++) step(1'b0, 1'b1, ins, d, h, a);
        if (!a) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: instr %0h not accepted, required acceptance", ins);
        end
    endtask

    // Monitor: pops expectations when the DUT presents an output.
    logic [7:0] mon_ppd = 8'h00;
    initial begin
        exp_t t;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            if (reset) begin
                mon_ppd = 8'h00;
                chk("rst_pp_instr", pp_instr, BUB);
                chk("rst_issue_valid", issue_valid, 0);
                chk("rst_result_valid", result_valid, 0);
                chk("rst_pp_data", pp_data, 0);
                continue;
            end
            while (q_issue.size() > 0 && q_issue[0].edge_n < cyc) begin
                t = q_issue.pop_front();
                chk("issue_missing_edge", cyc, t.edge_n);
            end
            if (issue_valid) begin
                if (q_issue.size() == 0) begin
                    chk("issue_spurious", issue_valid, 0);
                end else begin
                    t = q_issue.pop_front();
                    chk("issue_instr", pp_instr, t.val);
                    chk("issue_edge", cyc, t.edge_n);
                end
            end else begin
                chk("bubble_instr", pp_instr, BUB);
            end
            while (q_data.size() > 0 && q_data[0].edge_n <= cyc) begin
                t = q_data.pop_front();
                mon_ppd = t.val;
            end
            chk("pp_data", pp_data, mon_ppd);
            while (q_rv.size() > 0 && q_rv[0] < cyc) begin
                chk("rv_missing_edge", cyc, q_rv[0]);
                void'(q_rv.pop_front());
            end
            if (result_valid) begin
                if (q_rv.size() > 0 && q_rv[0] == cyc) begin
                    chk("rv_edge", cyc, q_rv[0]);
                    void'(q_rv.pop_front());
                end else begin
                    chk("rv_spurious", result_valid, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit a;
        m_clear();
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, a);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, a);
        @(posedge clk);
        #1;
        chk("reset_pp_instr", pp_instr, 8'hC0);
        chk("reset_pp_data", pp_data, 0);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_issue_cnt", issue_cnt, 0);
        chk("reset_stall_cnt", stall_cnt, 0);
        mon_en = 1'b1;

        // Independent pair back-to-back
        send(8'h11, 8'h00, 1'b0);
        send(8'h5C, 8'h00, 1'b0);
        idle(8);
        chk("t2_issue_cnt", issue_cnt, 2);
        chk("t2_stall_cnt", stall_cnt, 0);

        // RAW on r1: three bubbles
        send(8'h11, 8'h00, 1'b0);
        send(8'h0A, 8'h00, 1'b0);
        idle(10);
        chk("t3_issue_cnt", issue_cnt, 4);
        chk("t3_stall_cnt", stall_cnt, 3);

        // Load then reader of r3: no stall
        send(8'h83, 8'hA5, 1'b0);
        send(8'h1B, 8'h00, 1'b0);
        idle(10);
        chk("t4_issue_cnt", issue_cnt, 6);
        chk("t4_stall_cnt", stall_cnt, 3);
        chk("t4_pp_data", pp_data, 8'hA5);

        // Halt: four accepted, fifth held until the queue drains
        send(8'hC1, 8'h00, 1'b1);
        send(8'h0A, 8'h00, 1'b1);
        send(8'h85, 8'h77, 1'b1);
        send(8'h52, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h1B, 8'h00, 1'b1, a);
        chk("t5_fifth_held", a, 0);
        chk("t5_ready_low", req_ready, 0);
        send(8'h1B, 8'h00, 1'b0);
        idle(20);
        chk("t5_issue_cnt", issue_cnt, 11);
        chk("t5_busy_clear", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] ri;
            logic [7:0] rd;
            ri = 8'($urandom);
            rd = 8'($urandom);
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) < 6), ri, rd,
                 ($urandom_range(0, 9) == 0), a);
        end
        idle(12);

        // Reset two cycles after a load issues
        send(8'h86, 8'h3C, 1'b0);
        idle(2);
        step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, a);
        idle(10);
        chk("t6_issue_cnt", issue_cnt, 0);
        chk("t6_pp_data", pp_data, 0);

        idle(4);
        chk("drain_issue_q", q_issue.size(), 0);
        chk("drain_data_q", q_data.size(), 0);
        chk("drain_rv_q", q_rv.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
